// File: rtl/oled_pkg.sv
// +--------------------------------------------------------------------------+
// | oled_pkg : shared command encodings, FSM state type and page mapping      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package oled_pkg;

    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_GLYPH = 1'b1;

    typedef logic [2:0] state_t;
    localparam state_t c_INIT_CLR = 3'd0;
    localparam state_t c_IDLE     = 3'd1;
    localparam state_t c_CLEAR    = 3'd2;
    localparam state_t c_FETCH    = 3'd3;
    localparam state_t c_DONE     = 3'd4;

    // Linear frame-RAM address of (page, col); also used by the display scanner.
    function automatic int unsigned page_to_ram_addr(
        input int unsigned page,
        input int unsigned col,
        input int unsigned pages,
        input int unsigned cols,
        input int unsigned flip
    );
        int unsigned ram_page;
        ram_page = (flip != 0) ? (pages - 1 - page) : page;
        return ram_page * cols + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_text_writer_if.sv
// +--------------------------------------------------------------------------+
// | oled_text_writer_if : command handshake bundle for oled_text_writer       |
// | Optional field cmd_inv exists only when OLED_TXT_INVERT_EN is defined.    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface oled_text_writer_if #(
    parameter int COLS  = 128,
    parameter int PAGES = 8,
    parameter int MAX_W = 16
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_op;
    logic [$clog2(PAGES)-1:0]   cmd_page;
    logic [$clog2(COLS)-1:0]    cmd_col;
    logic [7:0]                 cmd_glyph;
    logic [$clog2(MAX_W):0]     cmd_w;
    logic [7:0]                 cmd_fill;
`ifdef OLED_TXT_INVERT_EN
    logic                       cmd_inv;
`endif

    modport master (
`ifdef OLED_TXT_INVERT_EN
        output cmd_inv,
`endif
        output cmd_valid, cmd_op, cmd_page, cmd_col, cmd_glyph, cmd_w, cmd_fill,
        input  cmd_ready
    );

    modport slave (
`ifdef OLED_TXT_INVERT_EN
        input  cmd_inv,
`endif
        input  cmd_valid, cmd_op, cmd_page, cmd_col, cmd_glyph, cmd_w, cmd_fill,
        output cmd_ready
    );

endinterface

`default_nettype wire

// File: rtl/oled_addr_map.sv
// +--------------------------------------------------------------------------+
// | oled_addr_map : (page, column) -> frame-RAM address plus clip flag        |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module oled_addr_map
    import oled_pkg::*;
#(
    parameter int COLS      = 128,
    parameter int PAGES     = 8,
    parameter int PAGE_FLIP = 1,
    parameter int PAGE_W    = 5,
    parameter int COL_W     = 8,
    parameter int ADDR_W    = 10
) (
    input  logic [PAGE_W-1:0] page,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              clip
);

    // Inputs are wide enough to carry overflow, so clipping never wraps.
    assign clip = (32'(page) >= 32'(PAGES)) || (32'(col) >= 32'(COLS));
    assign addr = ADDR_W'(page_to_ram_addr(32'(page), 32'(col), PAGES, COLS, PAGE_FLIP));

endmodule

`default_nettype wire

// File: rtl/oled_text_writer.sv
// +--------------------------------------------------------------------------+
// | oled_text_writer : clears the frame RAM and blits font glyphs into it     |
// | Optional feature macro: OLED_TXT_INVERT_EN (adds cmd_inv, glyph inversion)|
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module oled_text_writer
    import oled_pkg::*;
#(
    parameter int COLS        = 128,
    parameter int PAGES       = 8,
    parameter int GLYPH_PAGES = 2,
    parameter int MAX_W       = 16,
    parameter int FONT_AW     = 12,
    parameter int PAGE_FLIP   = 1,
    localparam int CW  = $clog2(COLS),
    localparam int PW  = $clog2(PAGES),
    localparam int WW  = $clog2(MAX_W) + 1,
    localparam int AW  = $clog2(PAGES * COLS),
    localparam int PGW = PW + 2,
    localparam int CLW = CW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    oled_text_writer_if.slave    cmd,
    output logic                 font_rd,
    output logic [FONT_AW-1:0]   font_addr,
    input  logic [7:0]           font_data,
    output logic                 wren,
    output logic [AW-1:0]        wraddress,
    output logic [7:0]           data,
    output logic                 busy,
    output logic                 done
);

    state_t             r_state;
    logic [PW-1:0]      r_page;
    logic [CW-1:0]      r_col;
    logic [7:0]         r_glyph;
    logic [WW-1:0]      r_w;
    logic [7:0]         r_fill;
    logic               r_glyph_mode;
    logic [WW-1:0]      r_c;
    logic [1:0]         r_r;
    logic               r_issue;
    logic               r_font_rd;
    logic [FONT_AW-1:0] r_font_addr;
    logic [AW-1:0]      r_pend_addr;
    logic               r_pend_clip;
    logic               r_wren;
    logic [AW-1:0]      r_wraddress;

    logic [PGW-1:0]     w_map_page;
    logic [CLW-1:0]     w_map_col;
    logic [AW-1:0]      w_map_addr;
    logic               w_map_clip;
    logic [FONT_AW-1:0] w_font_addr;
    logic               w_w_ok;
    logic               w_last;
    logic [7:0]         w_inv_mask;

`ifdef OLED_TXT_INVERT_EN
    logic               r_inv;
    assign w_inv_mask = {8{r_inv}};
`else
    assign w_inv_mask = 8'h00;
`endif

    assign w_map_page  = PGW'(r_page) + PGW'(r_r);
    assign w_map_col   = CLW'(r_col) + CLW'(r_c);
    assign w_font_addr = FONT_AW'(32'(r_glyph) * 32'(MAX_W * GLYPH_PAGES)
                                  + 32'(r_c) * 32'(GLYPH_PAGES) + 32'(r_r));
    assign w_w_ok      = (cmd.cmd_w != '0) && (32'(cmd.cmd_w) <= 32'(MAX_W));
    assign w_last      = (r_r == 2'(GLYPH_PAGES - 1)) && (r_c == r_w - WW'(1));

    oled_addr_map #(
        .COLS      (COLS),
        .PAGES     (PAGES),
        .PAGE_FLIP (PAGE_FLIP),
        .PAGE_W    (PGW),
        .COL_W     (CLW),
        .ADDR_W    (AW)
    ) u_addr_map (
        .page (w_map_page),
        .col  (w_map_col),
        .addr (w_map_addr),
        .clip (w_map_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_INIT_CLR;
            r_page       <= '0;
            r_col        <= '0;
            r_glyph      <= '0;
            r_w          <= '0;
            r_fill       <= '0;
            r_glyph_mode <= 1'b0;
            r_c          <= '0;
            r_r          <= '0;
            r_issue      <= 1'b0;
            r_font_rd    <= 1'b0;
            r_font_addr  <= '0;
            r_pend_addr  <= '0;
            r_pend_clip  <= 1'b0;
            r_wren       <= 1'b0;
            r_wraddress  <= '0;
`ifdef OLED_TXT_INVERT_EN
            r_inv        <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_INIT_CLR, c_CLEAR: begin
                    // Init clear arrives with wren low and must start at address 0.
                    if (!r_wren) begin
                        r_wren      <= 1'b1;
                        r_wraddress <= '0;
                    end else if (r_wraddress == '1) begin
                        r_wren  <= 1'b0;
                        r_state <= c_DONE;
                    end else begin
                        r_wraddress <= r_wraddress + 1'b1;
                    end
                end
                c_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_page       <= cmd.cmd_page;
                        r_col        <= cmd.cmd_col;
                        r_glyph      <= cmd.cmd_glyph;
                        r_w          <= cmd.cmd_w;
                        r_fill       <= cmd.cmd_fill;
                        r_glyph_mode <= (cmd.cmd_op == OP_GLYPH);
`ifdef OLED_TXT_INVERT_EN
                        r_inv        <= cmd.cmd_inv;
`endif
                        if (cmd.cmd_op == OP_CLEAR) begin
                            r_state     <= c_CLEAR;
                            r_wren      <= 1'b1;
                            r_wraddress <= '0;
                        end else begin
                            r_state <= c_FETCH;
                            r_issue <= w_w_ok;
                            r_c     <= '0;
                            r_r     <= '0;
                        end
                    end
                end
                c_FETCH: begin
                    // Write stage: consumes the byte read in the previous cycle.
                    r_wren <= r_font_rd && !r_pend_clip;
                    if (r_font_rd && !r_pend_clip) begin
                        r_wraddress <= r_pend_addr;
                    end
                    if (r_issue) begin
                        r_font_rd   <= 1'b1;
                        r_font_addr <= w_font_addr;
                        r_pend_addr <= w_map_addr;
                        r_pend_clip <= w_map_clip;
                        if (w_last) begin
                            r_issue <= 1'b0;
                        end else if (r_r == 2'(GLYPH_PAGES - 1)) begin
                            r_r <= '0;
                            r_c <= r_c + 1'b1;
                        end else begin
                            r_r <= r_r + 1'b1;
                        end
                    end else begin
                        r_font_rd <= 1'b0;
                        if (!r_font_rd) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = (r_state == c_IDLE);
    assign busy          = (r_state == c_INIT_CLR) || (r_state == c_CLEAR) || (r_state == c_FETCH);
    assign done          = (r_state == c_DONE);
    assign font_rd       = r_font_rd;
    assign font_addr     = r_font_addr;
    assign wren          = r_wren;
    assign wraddress     = r_wraddress;
    assign data          = !r_wren      ? 8'h00 :
                           r_glyph_mode ? (font_data ^ w_inv_mask) : r_fill;

endmodule

`default_nettype wire

// File: tb/tb_oled_text_writer.sv
// +--------------------------------------------------------------------------+
// | tb_oled_text_writer : randomized bench with a cycle-trace reference model |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_oled_text_writer;

    localparam int COLS    = 128;
    localparam int PAGES   = 8;
    localparam int GP      = 2;
    localparam int MAX_W   = 16;
    localparam int FONT_AW = 12;
    localparam int FLIP    = 1;
    localparam int NADDR   = PAGES * COLS;

    typedef struct {
        int wren; int addr; int data; int rd; int chk_fa; int fa;
        int busy; int done; int ready;
    } exp_t;

    typedef struct { int cyc; int addr; int data; } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        font_rd;
    logic [11:0] font_addr;
    logic [7:0]  font_data = 8'h00;
    logic        wren;
    logic [9:0]  wraddress;
    logic [7:0]  data;
    logic        busy;
    logic        done;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   m_last      = 0;
    int   acc_cyc     = 0;
    int   done_cyc    = -1;
    exp_t q[$];
    wr_t  wr_log[$];
    int   rd_log[$];

    always #5 clk = ~clk;

    oled_text_writer_if #(.COLS(COLS), .PAGES(PAGES), .MAX_W(MAX_W)) cmd_bus ();

    oled_text_writer #(
        .COLS(COLS), .PAGES(PAGES), .GLYPH_PAGES(GP), .MAX_W(MAX_W),
        .FONT_AW(FONT_AW), .PAGE_FLIP(FLIP)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd_bus.slave),
        .font_rd(font_rd), .font_addr(font_addr), .font_data(font_data),
        .wren(wren), .wraddress(wraddress), .data(data),
        .busy(busy), .done(done)
    );

    function automatic logic [7:0] rom_byte(input int a);
        return 8'(a * 29 + 15);
    endfunction

    always @(posedge clk) begin
        if (font_rd) font_data <= rom_byte(int'(font_addr));
    end

    function automatic void push_rec(input int wr, input int a, input int d, input int rd,
                                     input int fa, input int bsy, input int dn);
        exp_t e;
        if (wr != 0) m_last = a;
        e = '{wren:wr, addr:m_last, data:d, rd:rd, chk_fa:rd, fa:fa, busy:bsy, done:dn, ready:0};
        q.push_back(e);
    endfunction

    function automatic void push_reset_rec();
        exp_t e;
        m_last = 0;
        e = '{wren:0, addr:0, data:0, rd:0, chk_fa:1, fa:0, busy:1, done:0, ready:0};
        q.push_back(e);
    endfunction

    function automatic void push_fill(input int fill);
        for (int i = 0; i < NADDR; i++) push_rec(1, i, fill, 0, 0, 1, 0);
        push_rec(0, 0, 0, 0, 0, 0, 1);
    endfunction

    // Font address, RAM address and clip state of the k-th byte of a glyph.
    function automatic void glyph_item(input int glyph, input int page, input int col, input int k,
                                       output int fa, output int wa, output int clip);
        int c, r, pg, cl;
        c    = k / GP;
        r    = k % GP;
        pg   = page + r;
        cl   = col + c;
        clip = (pg >= PAGES || cl >= COLS) ? 1 : 0;
        wa   = ((FLIP != 0) ? (PAGES - 1 - pg) : pg) * COLS + cl;
        fa   = (glyph * MAX_W * GP + c * GP + r) % (1 << FONT_AW);
    endfunction

    function automatic void push_glyph(input int glyph, input int page, input int col,
                                       input int w, input int inv);
        int n, fa, wa, clip, pfa, pwa, pclip, wr, d;
        push_rec(0, 0, 0, 0, 0, 1, 0);
        if (w == 0 || w > MAX_W) begin
            push_rec(0, 0, 0, 0, 0, 0, 1);
            return;
        end
        n = w * GP;
        pfa = 0; pwa = 0; pclip = 1;
        for (int t = 0; t <= n; t++) begin
            fa = 0; wa = 0; clip = 1;
            if (t < n) glyph_item(glyph, page, col, t, fa, wa, clip);
            wr = (t > 0 && pclip == 0) ? 1 : 0;
            d  = (wr != 0) ? (int'(rom_byte(pfa)) ^ (inv != 0 ? 255 : 0)) : 0;
            push_rec(wr, pwa, d, (t < n) ? 1 : 0, fa, 1, 0);
            pfa = fa; pwa = wa; pclip = clip;
        end
        push_rec(0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(output bit was_idle);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (q.size() == 0) begin
            was_idle = 1'b1;
            e = '{wren:0, addr:m_last, data:0, rd:0, chk_fa:0, fa:0, busy:0, done:0, ready:1};
        end else begin
            was_idle = 1'b0;
            e = q.pop_front();
        end
        vectors++;
        chk("cmd_ready", int'(cmd_bus.cmd_ready), e.ready);
        chk("busy",      int'(busy),      e.busy);
        chk("done",      int'(done),      e.done);
        chk("wren",      int'(wren),      e.wren);
        chk("font_rd",   int'(font_rd),   e.rd);
        chk("wraddress", int'(wraddress), e.addr);
        chk("data",      int'(data),      e.data);
        if (e.chk_fa != 0) chk("font_addr", int'(font_addr), e.fa);
        if (wren)    wr_log.push_back('{cyc, int'(wraddress), int'(data)});
        if (font_rd) rd_log.push_back(int'(font_addr));
        if (done)    done_cyc = cyc;
    endtask

    // Busy cycles get random garbage on the command inputs; it must be ignored.
    task automatic tick(output bit idle);
        step(idle);
        if (idle) begin
            cmd_bus.cmd_valid = 1'b0;
        end else begin
            cmd_bus.cmd_valid = 1'($urandom_range(0, 1));
            cmd_bus.cmd_op    = 1'($urandom_range(0, 1));
            cmd_bus.cmd_page  = 3'($urandom_range(0, 7));
            cmd_bus.cmd_col   = 7'($urandom_range(0, 127));
            cmd_bus.cmd_glyph = 8'($urandom_range(0, 255));
            cmd_bus.cmd_w     = 5'($urandom_range(0, 31));
            cmd_bus.cmd_fill  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_idle();
        bit idle;
        int guard;
        idle = 1'b0;
        guard = 0;
        while (!idle && guard < 3000) begin
            tick(idle);
            guard++;
        end
        if (!idle) begin
            miscompares++;
            $display("FAIL idle_timeout cycle %0d: got busy expected idle", cyc);
        end
    endtask

    task automatic issue(input int op, input int page, input int col, input int glyph,
                         input int w, input int fill, input int inv);
        wait_idle();
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 1'(op);
        cmd_bus.cmd_page  = 3'(page);
        cmd_bus.cmd_col   = 7'(col);
        cmd_bus.cmd_glyph = 8'(glyph);
        cmd_bus.cmd_w     = 5'(w);
        cmd_bus.cmd_fill  = 8'(fill);
`ifdef OLED_TXT_INVERT_EN
        cmd_bus.cmd_inv   = 1'(inv);
`endif
        acc_cyc  = cyc;
        done_cyc = -1;
        wr_log.delete();
        rd_log.delete();
        if (op != 0) push_glyph(glyph, page, col, w, inv);
        else         push_fill(fill);
    endtask

    task automatic do_reset(input int n);
        bit idle;
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < n; i++) begin
            push_reset_rec();
            tick(idle);
        end
        rst      = 1'b0;
        acc_cyc  = cyc;
        done_cyc = -1;
        wr_log.delete();
        rd_log.delete();
        push_fill(0);
    endtask

    initial begin
        int nclr, zeros, op, col, w, inv;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 1'b0;
        cmd_bus.cmd_page  = '0;
        cmd_bus.cmd_col   = '0;
        cmd_bus.cmd_glyph = '0;
        cmd_bus.cmd_w     = '0;
        cmd_bus.cmd_fill  = '0;
`ifdef OLED_TXT_INVERT_EN
        cmd_bus.cmd_inv   = 1'b0;
`endif

        do_reset(3);
        wait_idle();
        chk("init_count", wr_log.size(), 1024);
        if (wr_log.size() == 1024) begin
            chk("init_first_addr", wr_log[0].addr, 0);
            chk("init_last_addr", wr_log[1023].addr, 1023);
            chk("init_done_cyc", done_cyc, acc_cyc + 1025);
        end

        issue(0, 0, 0, 0, 0, 8'hA5, 0);
        wait_idle();
        chk("clear_count", wr_log.size(), 1024);
        if (wr_log.size() == 1024) begin
            chk("clear_first_cyc", wr_log[0].cyc, acc_cyc + 1);
            chk("clear_first_data", wr_log[0].data, 8'hA5);
            chk("clear_done_cyc", done_cyc, wr_log[1023].cyc + 1);
        end

        issue(1, 2, 10, 3, 8, 0, 0);
        wait_idle();
        chk("g3_count", wr_log.size(), 16);
        chk("g3_reads", rd_log.size(), 16);
        if (wr_log.size() >= 2 && rd_log.size() >= 2) begin
            chk("g3_addr0", wr_log[0].addr, 650);
            chk("g3_addr1", wr_log[1].addr, 522);
            chk("g3_faddr0", rd_log[0], 96);
            chk("g3_faddr1", rd_log[1], 97);
            chk("g3_back2back", wr_log[1].cyc, wr_log[0].cyc + 1);
        end

        issue(1, 0, 124, 5, 8, 0, 0);
        wait_idle();
        chk("clipcol_count", wr_log.size(), 8);
        chk("clipcol_reads", rd_log.size(), 16);
        zeros = 0;
        foreach (wr_log[i]) if (wr_log[i].addr % COLS == 0) zeros++;
        chk("clipcol_col0_writes", zeros, 0);

        issue(1, 7, 0, 1, 4, 0, 0);
        wait_idle();
        chk("clippage_count", wr_log.size(), 4);
        chk("clippage_reads", rd_log.size(), 8);

        issue(1, 0, 0, 1, 0, 0, 0);
        wait_idle();
        chk("w0_count", wr_log.size(), 0);
        chk("w0_done_cyc", done_cyc, acc_cyc + 2);

        issue(1, 0, 0, 1, 17, 0, 0);
        wait_idle();
        chk("w17_count", wr_log.size(), 0);

`ifdef OLED_TXT_INVERT_EN
        issue(1, 0, 0, 0, 1, 0, 1);
        wait_idle();
        chk("inv_count", wr_log.size(), 2);
        if (wr_log.size() >= 1) chk("inv_data", wr_log[0].data, 8'hF0);
`endif

        nclr = 0;
        for (int i = 0; i < 60; i++) begin
            op  = 1;
            if ($urandom_range(0, 15) == 0 && nclr < 2) begin op = 0; nclr++; end
            col = ($urandom_range(0, 3) == 0) ? $urandom_range(112, 127) : $urandom_range(0, 127);
            w   = $urandom_range(0, 19);
`ifdef OLED_TXT_INVERT_EN
            inv = $urandom_range(0, 1);
`else
            inv = 0;
`endif
            issue(op, $urandom_range(0, 7), col, $urandom_range(0, 255), w,
                  $urandom_range(0, 255), inv);
        end

        issue(1, 3, 20, 9, 16, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bit idle;
            tick(idle);
        end
        do_reset(2);
        wait_idle();
        chk("rst_init_count", wr_log.size(), 1024);
        if (wr_log.size() >= 1) begin
            chk("rst_init_addr0", wr_log[0].addr, 0);
            chk("rst_init_cyc0", wr_log[0].cyc, acc_cyc + 1);
        end

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
